// File: rtl/fifo_reader.sv
// Pulls words from a show-ahead-less FIFO (one-cycle read latency) into a 2-entry buffer
// and presents them as a valid/ready stream. Optional delivered-word counter: FIFO_READER_COUNT_EN.
module fifo_reader #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             empty_bar,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             get,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
`ifdef FIFO_READER_COUNT_EN
   ,
   output logic [15:0]      word_count
`endif
);

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

   logic [1:0]       r_occ;
   logic             r_pend;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;

   logic             w_pop;
   logic             w_cap;
   logic [2:0]       w_sum;
   logic [1:0]       w_occ_nxt;
   logic [WIDTH-1:0] w_head_nxt;
   logic [WIDTH-1:0] w_tail_nxt;

   // A fetch is only issued when the word it returns is guaranteed a free slot.
   assign w_pop   = m_valid & m_ready;
   assign w_cap   = r_pend;
   assign w_sum   = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
   assign get     = empty_bar & ~reset & (w_sum < 3'd2);
   assign m_valid = (r_occ != OCC_EMPTY) & ~reset;
   assign m_data  = r_head;

   // Buffer next-state: capture into tail, pop from head, both in one edge when needed.
   always_comb begin
      w_occ_nxt  = r_occ;
      w_head_nxt = r_head;
      w_tail_nxt = r_tail;
      case (r_occ)
         OCC_EMPTY: begin
            if (w_cap) begin
               w_head_nxt = fifo_data;
               w_occ_nxt  = OCC_ONE;
            end else begin
               w_occ_nxt  = OCC_EMPTY;
            end
         end
         OCC_ONE: begin
            if (w_cap && w_pop) begin
               w_head_nxt = fifo_data;
            end else if (w_cap) begin
               w_tail_nxt = fifo_data;
               w_occ_nxt  = OCC_TWO;
            end else if (w_pop) begin
               w_occ_nxt  = OCC_EMPTY;
            end else begin
               w_occ_nxt  = OCC_ONE;
            end
         end
         OCC_TWO: begin
            if (w_pop) begin
               w_head_nxt = r_tail;
               if (w_cap) begin
                  w_tail_nxt = fifo_data;
               end else begin
                  w_occ_nxt  = OCC_ONE;
               end
            end else begin
               w_occ_nxt = OCC_TWO;
            end
         end
         default: begin
            w_occ_nxt = OCC_EMPTY;
         end
      endcase
   end

   // State registers; reset also drops any word still in flight from the FIFO.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_occ  <= OCC_EMPTY;
         r_pend <= 1'b0;
         r_head <= {WIDTH{1'b0}};
         r_tail <= {WIDTH{1'b0}};
      end else begin
         r_occ  <= w_occ_nxt;
         r_pend <= get;
         r_head <= w_head_nxt;
         r_tail <= w_tail_nxt;
      end
   end

`ifdef FIFO_READER_COUNT_EN
   logic [15:0] r_count;

   // Delivered-word counter, wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= 16'd0;
      end else if (w_pop) begin
         r_count <= r_count + 16'd1;
      end else begin
         r_count <= r_count;
      end
   end

   assign word_count = r_count;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a one-cycle-latency FIFO model feeds the DUT and each
// scenario task checks get/valid timing and delivered words against hand-derived values.
module tb_fifo_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        empty_bar;
   logic [15:0] fifo_data = 16'h0000;
   logic        get;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
`ifdef FIFO_READER_COUNT_EN
   logic [15:0] word_count;
`endif

   logic [15:0] mem [0:255];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   int          n_cmp  = 0;
   int          n_bad  = 0;

   logic [15:0] obs [$];
   int          gets;
   int          viol;
   logic [63:0] gpat;
   logic [63:0] vpat;

   always #5 clk = ~clk;

   fifo_reader #(.WIDTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .empty_bar (empty_bar),
      .fifo_data (fifo_data),
      .get       (get),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data)
`ifdef FIFO_READER_COUNT_EN
      ,
      .word_count(word_count)
`endif
   );

   // FIFO model: the word popped on a get edge appears on fifo_data after that edge.
   assign empty_bar = (wr_ptr != rd_ptr);
   always @(posedge clk) begin
      if (get) begin
         fifo_data <= mem[rd_ptr % 256];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   task automatic load(input logic [15:0] w);
      mem[wr_ptr % 256] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   // mode 0: ready high, 1: ready low, 2: ready alternating starting high
   task automatic run(input int ncyc, input int mode);
      obs.delete();
      gets = 0;
      viol = 0;
      gpat = '0;
      vpat = '0;
      for (int i = 0; i < ncyc; i++) begin
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            default: m_ready = ((i % 2) == 0);
         endcase
         #1;
         if (get) begin
            gets++;
            if (i < 64) gpat[i] = 1'b1;
         end
         if (get && !empty_bar) viol++;
         if (m_valid && i < 64) vpat[i] = 1'b1;
         if (m_valid && m_ready) obs.push_back(m_data);
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      m_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (get !== 1'b0) begin n_bad++; $display("FAIL rst_get: got %b want 0", get); end
      n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", m_valid); end
      n_cmp++; if (m_data !== 16'h0000) begin n_bad++; $display("FAIL rst_data: got %h want 0000", m_data); end
`ifdef FIFO_READER_COUNT_EN
      n_cmp++; if (word_count !== 16'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", word_count); end
`endif
      load(16'hBEEF);
      #1;
      n_cmp++; if (get !== 1'b0) begin n_bad++; $display("FAIL rst_gates_get: got %b want 0", get); end
      @(negedge clk);
      reset = 1'b0;
      run(6, 0);
      n_cmp++; if (gpat[5:0] !== 6'b000001) begin n_bad++; $display("FAIL rst_resume_get: got %b want 000001", gpat[5:0]); end
      n_cmp++; if (vpat[5:0] !== 6'b000100) begin n_bad++; $display("FAIL rst_resume_valid: got %b want 000100", vpat[5:0]); end
      n_cmp++; if (obs.size() != 1 || obs[0] !== 16'hBEEF) begin
         n_bad++; $display("FAIL rst_resume_data: got %0d words first %h want 1 word beef", obs.size(), (obs.size() > 0) ? obs[0] : 16'hxxxx);
      end
   endtask

   task automatic test_single();
      load(16'h1234);
      run(6, 0);
      n_cmp++; if (gpat[5:0] !== 6'b000001) begin n_bad++; $display("FAIL single_get: got %b want 000001", gpat[5:0]); end
      n_cmp++; if (vpat[5:0] !== 6'b000100) begin n_bad++; $display("FAIL single_valid: got %b want 000100", vpat[5:0]); end
      n_cmp++; if (obs.size() != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", obs.size()); end
      else if (obs[0] !== 16'h1234) begin n_cmp++; n_bad++; $display("FAIL single_data: got %h want 1234", obs[0]); end
   endtask

   task automatic test_burst();
      for (int k = 1; k <= 8; k++) load(16'(k));
      run(14, 0);
      n_cmp++; if (gpat[13:0] !== 14'h00FF) begin n_bad++; $display("FAIL burst_get: got %h want 00ff", gpat[13:0]); end
      n_cmp++; if (vpat[13:0] !== 14'h03FC) begin n_bad++; $display("FAIL burst_valid: got %h want 03fc", vpat[13:0]); end
      n_cmp++; if (obs.size() != 8) begin n_bad++; $display("FAIL burst_count: got %0d want 8", obs.size()); end
      for (int k = 0; k < obs.size() && k < 8; k++) begin
         n_cmp++; if (obs[k] !== 16'(k + 1)) begin n_bad++; $display("FAIL burst_data[%0d]: got %h want %h", k, obs[k], 16'(k + 1)); end
      end
   endtask

   task automatic test_backpressure();
      for (int k = 1; k <= 8; k++) load(16'(k));
      run(6, 1);
      n_cmp++; if (gets != 2) begin n_bad++; $display("FAIL bp_gets: got %0d want 2", gets); end
      n_cmp++; if (gpat[5:0] !== 6'b000011) begin n_bad++; $display("FAIL bp_get_pat: got %b want 000011", gpat[5:0]); end
      n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", m_valid); end
      n_cmp++; if (m_data !== 16'h0001) begin n_bad++; $display("FAIL bp_hold: got %h want 0001", m_data); end
      run(16, 0);
      n_cmp++; if (obs.size() != 8) begin n_bad++; $display("FAIL bp_count: got %0d want 8", obs.size()); end
      for (int k = 0; k < obs.size() && k < 8; k++) begin
         n_cmp++; if (obs[k] !== 16'(k + 1)) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", k, obs[k], 16'(k + 1)); end
      end
   endtask

   task automatic test_alternating();
      for (int k = 1; k <= 4; k++) load(16'h0A00 + 16'(k));
      run(20, 2);
      n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL alt_get_when_empty: got %0d want 0", viol); end
      n_cmp++; if (gets != 4) begin n_bad++; $display("FAIL alt_gets: got %0d want 4", gets); end
      n_cmp++; if (obs.size() != 4) begin n_bad++; $display("FAIL alt_count: got %0d want 4", obs.size()); end
      for (int k = 0; k < obs.size() && k < 4; k++) begin
         n_cmp++; if (obs[k] !== 16'h0A00 + 16'(k + 1)) begin n_bad++; $display("FAIL alt_data[%0d]: got %h want %h", k, obs[k], 16'h0A00 + 16'(k + 1)); end
      end
   endtask

   task automatic test_reset_midfetch();
      load(16'h7777);
      run(1, 0);
      n_cmp++; if (gets != 1) begin n_bad++; $display("FAIL mid_get: got %0d want 1", gets); end
      reset   = 1'b1;
      m_ready = 1'b1;
      #1;
      n_cmp++; if (get !== 1'b0) begin n_bad++; $display("FAIL mid_get_in_reset: got %b want 0", get); end
      n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid_in_reset: got %b want 0", m_valid); end
      @(negedge clk);
      reset = 1'b0;
      n_cmp++; if (m_data !== 16'h0000) begin n_bad++; $display("FAIL mid_no_capture: got %h want 0000", m_data); end
`ifdef FIFO_READER_COUNT_EN
      n_cmp++; if (word_count !== 16'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", word_count); end
`endif
      run(6, 0);
      n_cmp++; if (gets != 0) begin n_bad++; $display("FAIL mid_idle_get: got %0d want 0", gets); end
      n_cmp++; if (vpat[5:0] !== 6'b000000) begin n_bad++; $display("FAIL mid_idle_valid: got %b want 000000", vpat[5:0]); end
   endtask

`ifdef FIFO_READER_COUNT_EN
   task automatic test_count();
      int p;
      for (int k = 1; k <= 5; k++) load(16'(k));
      run(12, 0);
      n_cmp++; if (word_count !== 16'd5) begin n_bad++; $display("FAIL count_five: got %0d want 5", word_count); end
      p = 5;
      m_ready = 1'b1;
      for (int c = 0; c < 70000 && p < 65535; c++) begin
         if (wr_ptr - rd_ptr < 64) load(16'(c));
         #1;
         if (m_valid && m_ready) p++;
         @(negedge clk);
      end
      n_cmp++; if (word_count !== 16'hFFFF) begin n_bad++; $display("FAIL count_ffff: got %h want ffff", word_count); end
      load(16'h0);
      for (int c = 0; c < 8 && p < 65536; c++) begin
         #1;
         if (m_valid && m_ready) p++;
         @(negedge clk);
      end
      n_cmp++; if (word_count !== 16'h0000) begin n_bad++; $display("FAIL count_wrap: got %h want 0000", word_count); end
      m_ready = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_backpressure();
      test_alternating();
      test_reset_midfetch();
`ifdef FIFO_READER_COUNT_EN
      test_count();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
